// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode selectors and
// parameter sanity helpers used at elaboration time.
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit thresholds_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8,
    parameter int AW         = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    // Contents are intentionally not reset; occupancy tracking makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_th.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// thresholds, and overflow/underflow pulses backed by sticky error flags.
module sync_fifo_th
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(DATA_DEPTH):0]   fifo_cnt,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          overflow_err,
    output logic                          underflow_err
);

    localparam int AW = $clog2(DATA_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DATA_DEPTH);
    localparam logic [AW:0] AF_CNT    = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] AE_CNT    = (AW + 1)'(AE_THRESH);

    if (!is_pow2(DATA_DEPTH) || (DATA_DEPTH < 2)) begin : g_bad_depth
        $error("sync_fifo_th: DATA_DEPTH must be a power of two and at least 2");
    end

    if (!thresholds_ok(DATA_DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_th: AF_THRESH or AE_THRESH out of range");
    end

    if ((FWFT != FIFO_MODE_STD) && (FWFT != FIFO_MODE_FWFT)) begin : g_bad_mode
        $error("sync_fifo_th: FWFT must be 0 or 1");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           cnt_next;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  wr_reject;
    logic                  rd_reject;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Acceptance is decided on the registered flags so a full FIFO can still
    // take a read and refuse the coincident write in the same cycle.
    assign wr_fire   = wr_en & ~full;
    assign rd_fire   = rd_en & ~empty;
    assign wr_reject = wr_en & full;
    assign rd_reject = rd_en & empty;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .AW         (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        cnt_next = fifo_cnt;
        if (wr_fire && !rd_fire) begin
            cnt_next = fifo_cnt + 1'b1;
        end else if (rd_fire && !wr_fire) begin
            cnt_next = fifo_cnt - 1'b1;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
        end else begin
            fifo_cnt <= cnt_next;
            empty    <= (cnt_next == '0);
            full     <= (cnt_next == DEPTH_CNT);
        end
    end

    assign almost_full  = (fifo_cnt >= AF_CNT);
    assign almost_empty = (fifo_cnt <= AE_CNT);

    // A new rejection takes priority over a coincident clear so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            overflow  <= wr_reject;
            underflow <= rd_reject;
            if (wr_reject) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (rd_reject) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown directly; forced to zero while empty so stale memory never leaks out.
        assign data_out = empty ? '0 : ram_rd_data;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_fire) begin
                dout_q <= ram_rd_data;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_th.sv
// Bench driving a standard-mode and an FWFT-mode FIFO in lockstep against a
// queue-based model, with directed scenarios and literal spot checks.
module tb_sync_fifo_th;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic       err_clr;

    logic [7:0] s_dout, f_dout;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf, s_ovf_err, s_unf_err;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_ovf_err, f_unf_err;
    logic [3:0] s_cnt, f_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_th #(.DATA_WIDTH(8), .DATA_DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .err_clr(err_clr),
        .data_out(s_dout), .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .fifo_cnt(s_cnt), .overflow(s_ovf), .underflow(s_unf),
        .overflow_err(s_ovf_err), .underflow_err(s_unf_err)
    );

    sync_fifo_th #(.DATA_WIDTH(8), .DATA_DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .err_clr(err_clr),
        .data_out(f_dout), .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .fifo_cnt(f_cnt), .overflow(f_ovf), .underflow(f_unf),
        .overflow_err(f_ovf_err), .underflow_err(f_unf_err)
    );

    // Model: a plain queue of stored words plus the registered side effects of each edge.
    logic [7:0] mq[$];
    logic [7:0] m_std_out;
    bit         m_ovf, m_unf, m_ovf_err, m_unf_err;
    bit         model_ready = 1'b0;

    always @(posedge clk) begin
        bit wf, rf;
        if (rst) begin
            mq.delete();
            m_std_out   = 8'h00;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            m_ovf_err   = 1'b0;
            m_unf_err   = 1'b0;
            model_ready = 1'b1;
        end else begin
            wf    = wr_en && (mq.size() < 8);
            rf    = rd_en && (mq.size() > 0);
            m_ovf = wr_en && (mq.size() == 8);
            m_unf = rd_en && (mq.size() == 0);
            if (rf) m_std_out = mq.pop_front();
            if (wf) mq.push_back(data_in);
            m_ovf_err = m_ovf ? 1'b1 : (err_clr ? 1'b0 : m_ovf_err);
            m_unf_err = m_unf ? 1'b1 : (err_clr ? 1'b0 : m_unf_err);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compareDut(input string tag, input logic [3:0] cnt, input logic emp, input logic ful,
                              input logic ae, input logic af, input logic ovf, input logic unf,
                              input logic oerr, input logic uerr);
        int n;
        n = mq.size();
        checkOutput({tag, "_cnt"},   int'(cnt),  n);
        checkOutput({tag, "_empty"}, int'(emp),  int'(n == 0));
        checkOutput({tag, "_full"},  int'(ful),  int'(n == 8));
        checkOutput({tag, "_ae"},    int'(ae),   int'(n <= 1));
        checkOutput({tag, "_af"},    int'(af),   int'(n >= 6));
        checkOutput({tag, "_ovf"},   int'(ovf),  int'(m_ovf));
        checkOutput({tag, "_unf"},   int'(unf),  int'(m_unf));
        checkOutput({tag, "_oerr"},  int'(oerr), int'(m_ovf_err));
        checkOutput({tag, "_uerr"},  int'(uerr), int'(m_unf_err));
    endtask

    always @(negedge clk) begin
        if (model_ready) begin
            compareDut("std", s_cnt, s_empty, s_full, s_ae, s_af, s_ovf, s_unf, s_ovf_err, s_unf_err);
            compareDut("fwft", f_cnt, f_empty, f_full, f_ae, f_af, f_ovf, f_unf, f_ovf_err, f_unf_err);
            checkOutput("std_dout", int'(s_dout), int'(m_std_out));
            if (mq.size() > 0) checkOutput("fwft_dout", int'(f_dout), int'(mq[0]));
        end
    end

    task automatic applyStimulus(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        err_clr = c;
        rst     = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        applyStimulus(0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("rst_cnt", int'(s_cnt), 0);
        checkOutput("rst_empty", int'(f_empty), 1);
        checkOutput("rst_std_dout", int'(s_dout), 0);
        checkOutput("rst_fwft_dout", int'(f_dout), 0);
        checkOutput("rst_ae", int'(s_ae), 1);

        // Fill with 0x11..0x88, then one write too many.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 8'((i + 1) * 8'h11), 0, 0, 0);
            checkOutput("fill_cnt", int'(s_cnt), i + 1);
            checkOutput("fill_af", int'(f_af), int'(i + 1 >= 6));
        end
        checkOutput("fill_full", int'(s_full), 1);
        applyStimulus(1, 8'h99, 0, 0, 0);
        checkOutput("ovf_pulse", int'(s_ovf), 1);
        checkOutput("ovf_err", int'(f_ovf_err), 1);
        checkOutput("ovf_cnt", int'(f_cnt), 8);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("ovf_one_cycle", int'(s_ovf), 0);

        // Drain in order; FWFT shows each word before it is acknowledged.
        for (int i = 0; i < 8; i++) begin
            checkOutput("fwft_head", int'(f_dout), (i + 1) * 8'h11);
            applyStimulus(0, 8'h00, 1, 0, 0);
            checkOutput("std_read", int'(s_dout), (i + 1) * 8'h11);
        end
        checkOutput("drain_empty", int'(s_empty), 1);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("unf_pulse", int'(f_unf), 1);
        checkOutput("unf_hold_dout", int'(s_dout), 8'h88);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("clr_oerr", int'(s_ovf_err), 0);
        checkOutput("clr_uerr", int'(f_unf_err), 0);

        // Four words, then steady simultaneous traffic across pointer wrap.
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(i + 1), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 8'(8'h20 + i), 1, 0, 0);
            checkOutput("steady_cnt", int'(s_cnt), 4);
        end
        checkOutput("steady_last", int'(s_dout), 8'h20 + 15);

        // Both requests at full: read wins, write is refused and its word never appears.
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'(8'hA0 + i), 0, 0, 0);
        applyStimulus(1, 8'hEE, 1, 0, 0);
        checkOutput("full_both_cnt", int'(s_cnt), 7);
        checkOutput("full_both_ovf", int'(s_ovf), 1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 8'h00, 1, 0, 0);
            checkOutput("no_rejected_word", int'(s_dout == 8'hEE), 0);
        end
        applyStimulus(1, 8'h5A, 1, 0, 0);
        checkOutput("empty_both_cnt", int'(f_cnt), 1);
        checkOutput("empty_both_unf", int'(f_unf), 1);
        checkOutput("empty_both_fwft", int'(f_dout), 8'h5A);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("empty_both_read", int'(s_dout), 8'h5A);

        // Reset in the middle of operation.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h40 + i), 0, 0, 0);
        checkOutput("pre_rst_cnt", int'(s_cnt), 5);
        applyStimulus(1, 8'hFF, 1, 0, 1);
        checkOutput("mid_rst_cnt", int'(s_cnt), 0);
        checkOutput("mid_rst_empty", int'(f_empty), 1);
        checkOutput("mid_rst_dout", int'(s_dout), 0);
        checkOutput("mid_rst_fwft_dout", int'(f_dout), 0);
        checkOutput("mid_rst_errs", int'({s_ovf_err, s_unf_err, f_ovf_err, f_unf_err}), 0);
        applyStimulus(1, 8'h77, 0, 0, 0);
        checkOutput("post_rst_fwft", int'(f_dout), 8'h77);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("post_rst_read", int'(s_dout), 8'h77);

        // Sticky error: a clear that coincides with a fresh overflow does not win.
        for (int i = 0; i < 8; i++) applyStimulus(1, 8'(8'hC0 + i), 0, 0, 0);
        applyStimulus(1, 8'hD0, 0, 0, 0);
        checkOutput("sticky_set", int'(s_ovf_err), 1);
        applyStimulus(1, 8'hD1, 0, 1, 0);
        checkOutput("sticky_set_wins", int'(f_ovf_err), 1);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("sticky_cleared", int'(s_ovf_err), 0);
        applyStimulus(0, 8'h00, 0, 0, 0);
        checkOutput("sticky_stays_clear", int'(f_ovf_err), 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
